// File: rtl/dmem_block_if.sv
// Bus between the data cache and dmem_block: level requests in, registered
// block data and a combinational busywait back.
interface dmem_block_if;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    modport master (
        output mem_read,
        output mem_write,
        output mem_address,
        output mem_writedata,
        input  mem_readdata,
        input  mem_busywait
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_address,
        input  mem_writedata,
        output mem_readdata,
        output mem_busywait
    );
endinterface

// File: rtl/dmem_block.sv
// 64 x 32-bit block memory behind the data cache, fixed LATENCY per access.
// Optional DMEM_CLEAR_ON_RESET_EN zeroes the whole array while reset is low.
module dmem_block #(
    parameter int LATENCY = 5
) (
    input  logic         clock,
    input  logic         reset,
    dmem_block_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam bit         SINGLE_CYCLE = (LATENCY == 1);
    localparam logic [3:0] COUNT_INIT   = 4'(LATENCY - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  count;
    logic [5:0]  cap_address;
    logic [31:0] cap_writedata;
    logic        cap_write;
    logic [31:0] readdata_q;
    logic [31:0] mem_array [64];

    logic        request;
    logic        accept;
    logic        complete;
    logic        busywait;
    logic        op_write;
    logic [5:0]  op_address;
    logic [31:0] op_data;

    assign request = bus.mem_read | bus.mem_write;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = SINGLE_CYCLE ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (complete) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // With LATENCY=1 the operation happens on the accepting edge, so it must
    // use the live bus values; otherwise the values captured at acceptance.
    always_comb begin
        accept     = reset && (state == IDLE) && request;
        complete   = (accept && SINGLE_CYCLE) || (state == ACCESS && count == 4'd1);
        busywait   = reset && ((state == IDLE && request) || state == ACCESS);
        op_write   = (state == IDLE) ? bus.mem_write     : cap_write;
        op_address = (state == IDLE) ? bus.mem_address   : cap_address;
        op_data    = (state == IDLE) ? bus.mem_writedata : cap_writedata;
    end

    // The ACCESS phase ends on the edge that takes the counter to zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count         <= 4'd0;
            cap_address   <= 6'd0;
            cap_writedata <= 32'd0;
            cap_write     <= 1'b0;
        end else if (accept) begin
            count         <= COUNT_INIT;
            cap_address   <= bus.mem_address;
            cap_writedata <= bus.mem_writedata;
            cap_write     <= bus.mem_write;
        end else if (state == ACCESS && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            readdata_q <= 32'd0;
        end else if (complete && !op_write) begin
            readdata_q <= mem_array[op_address];
        end
    end

`ifdef DMEM_CLEAR_ON_RESET_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) begin
                mem_array[i] <= 32'd0;
            end
        end else if (complete && op_write) begin
            mem_array[op_address] <= op_data;
        end
    end
`else
    // complete is gated by reset, so a write in flight at reset is dropped.
    always_ff @(posedge clock) begin
        if (complete && op_write) begin
            mem_array[op_address] <= op_data;
        end
    end
`endif

    assign bus.mem_readdata = readdata_q;
    assign bus.mem_busywait = busywait;

endmodule

// File: tb/tb_dmem_block.sv
// Scoreboard bench for dmem_block: one instance at LATENCY=5, one at LATENCY=1,
// checked against a plain array model of the block memory.
module tb_dmem_block;

    localparam int LAT_A = 5;
    localparam int LAT_B = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        drv_read = 1'b0;
    logic        drv_write = 1'b0;
    logic [5:0]  drv_address = 6'd0;
    logic [31:0] drv_writedata = 32'd0;
    logic        sel = 1'b0;

    dmem_block_if if_a ();
    dmem_block_if if_b ();

    assign if_a.mem_read      = drv_read & ~sel;
    assign if_a.mem_write     = drv_write & ~sel;
    assign if_a.mem_address   = drv_address;
    assign if_a.mem_writedata = drv_writedata;
    assign if_b.mem_read      = drv_read & sel;
    assign if_b.mem_write     = drv_write & sel;
    assign if_b.mem_address   = drv_address;
    assign if_b.mem_writedata = drv_writedata;

    dmem_block #(.LATENCY(LAT_A)) dut_a (.clock(clock), .reset(reset), .bus(if_a.slave));
    dmem_block #(.LATENCY(LAT_B)) dut_b (.clock(clock), .reset(reset), .bus(if_b.slave));

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rdata;
        int          busy_cycles;
    } exp_t;

    exp_t        exp_q [$];
    int          n_vectors = 0;
    int          n_miscompares = 0;
    logic [31:0] model [2][64];
    logic [31:0] last_rd [2];

    function automatic logic cur_busy();
        return sel ? if_b.mem_busywait : if_a.mem_busywait;
    endfunction

    function automatic logic [31:0] cur_rdata();
        return sel ? if_b.mem_readdata : if_a.mem_readdata;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_vectors++;
        if (actual !== required) begin
            n_miscompares++;
            $display("[TB] FAIL %s: actual %h required %h (t=%0t)", name, actual, required, $time);
        end
    endtask

    // A write (alone or with a read) updates the word; only a pure read moves readdata.
    task automatic push_expect(input logic rd, input logic wr, input logic [5:0] addr, input logic [31:0] data);
        exp_t e;
        int   s;
        s = sel ? 1 : 0;
        if (wr) begin
            model[s][addr] = data;
        end else if (rd) begin
            last_rd[s] = model[s][addr];
        end
        e.rdata       = last_rd[s];
        e.busy_cycles = sel ? LAT_B : LAT_A;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input bit scramble, input bit hold);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clock);
            #2;
            if (!cur_busy()) begin
                done = 1'b1;
            end else if (scramble && c == 1) begin
                drv_address   = 6'($urandom);
                drv_writedata = $urandom;
            end
        end
        check_output("completion_timeout", {31'd0, done}, 32'd1);
        if (!hold) begin
            drv_read  = 1'b0;
            drv_write = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input logic rd, input logic wr, input logic [5:0] addr,
                                  input logic [31:0] data, input bit scramble, input bit hold);
        @(posedge clock);
        #1;
        drv_read      = rd;
        drv_write     = wr;
        drv_address   = addr;
        drv_writedata = data;
        push_expect(rd, wr, addr, data);
        wait_done(scramble, hold);
    endtask

    // Monitor: every falling busywait marks a DONE cycle, checked against the queue head.
    int   busy_cnt = 0;
    logic prev_busy = 1'b0;
    logic mon_busy;
    exp_t mon_exp;

    always @(negedge clock) begin
        if (!reset) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
        end else begin
            mon_busy = cur_busy();
            if (mon_busy) begin
                busy_cnt++;
            end else if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check_output("readdata", cur_rdata(), mon_exp.rdata);
                    check_output("busy_cycles", 32'(busy_cnt), 32'(mon_exp.busy_cycles));
                end
                busy_cnt = 0;
            end
            prev_busy = mon_busy;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int op;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;

        #12;
        check_output("reset_busy_a", {31'd0, if_a.mem_busywait}, 32'd0);
        check_output("reset_rdata_a", if_a.mem_readdata, 32'd0);
        check_output("reset_rdata_b", if_b.mem_readdata, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 64; i++) begin
            apply_stimulus(1'b0, 1'b1, 6'(i), $urandom, 1'b0, 1'b0);
        end

        apply_stimulus(1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 6'h2A, 32'h0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 6'h05, 32'h11223344, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 6'h05, 32'h0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 6'h10, 32'h77777777, 1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0, 6'h10, 32'h0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 6'h3F, 32'hA5A5A5A5, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 6'h3F, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 120; i++) begin
            op = $urandom_range(0, 3);
            apply_stimulus(op == 0 || op == 2 || op == 3, op == 1 || op == 2, 6'($urandom),
                           $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        // Reset in the middle of a write: the word must keep its old value.
        @(posedge clock);
        #1;
        drv_read      = 1'b0;
        drv_write     = 1'b1;
        drv_address   = 6'h11;
        drv_writedata = 32'hCAFEF00D;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check_output("abort_busy", {31'd0, if_a.mem_busywait}, 32'd0);
        check_output("abort_rdata", if_a.mem_readdata, 32'd0);
        drv_write  = 1'b0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
`ifdef DMEM_CLEAR_ON_RESET_EN
        for (int i = 0; i < 64; i++) begin
            model[0][i] = 32'd0;
            model[1][i] = 32'd0;
        end
`endif
        @(posedge clock);
        #1;
        drv_read    = 1'b1;
        drv_address = 6'h11;
        push_expect(1'b1, 1'b0, 6'h11, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        wait_done(1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            apply_stimulus(1'b1, 1'b0, 6'($urandom), 32'h0, 1'b0, 1'b0);
        end

        @(posedge clock);
        #1;
        drv_read  = 1'b0;
        drv_write = 1'b0;
        sel       = 1'b1;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 1'b1, 6'(i), $urandom, 1'b0, 1'b0);
        end
        apply_stimulus(1'b1, 1'b0, 6'h00, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 3);
            apply_stimulus(op != 1, op == 1 || op == 2, 6'($urandom_range(0, 7)),
                           $urandom, 1'b0, $urandom_range(0, 3) == 0);
        end

        @(posedge clock);
        #1;
        drv_read  = 1'b0;
        drv_write = 1'b0;
        repeat (5) @(posedge clock);
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
